obj_fetch_unit: RTL and testbench

// Read side of video memory: on each frame start, walks the live-object bitmap from object_unit,

---
 rtl/vpu_pkg.sv | 47 ++++
 rtl/obj_map_scan.sv | 22 ++
 rtl/obj_fetch_unit.sv | 207 ++++++++++++++++++++
 tb/tb_obj_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared video-pipeline types: object record layout, primitive types,
// fetch FSM states and per-primitive vertex/segment counts.
package vpu_pkg;

  localparam int OBJ_REC_W = 144;
  localparam int COORD_W   = 16;
  localparam int VERT_W    = 2 * COORD_W;
  localparam int MAX_VERTS = 4;
  localparam int TYPE_LSB  = 128;
  localparam int TYPE_W    = 2;
  localparam int COLOR_LSB = 130;
  localparam int COLOR_W   = 8;
  localparam int RSVD_LSB  = 138;

  typedef enum logic [1:0] {
    PT,
    LINE,
    TRI,
    QUAD
  } obj_type_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT,
    EMIT
  } fetch_state_t;

  function automatic logic [2:0] nverts(obj_type_t t);
    return {1'b0, t} + 3'd1;
  endfunction

  // A line is a single open segment; closed shapes wrap back to p0.
  function automatic logic [2:0] nsegs(obj_type_t t);
    logic [2:0] n;
    case (t)
      PT:      n = 3'd1;
      LINE:    n = 3'd1;
      TRI:     n = 3'd3;
      QUAD:    n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/obj_map_scan.sv
// Lowest-set-bit encoder over the live-object bitmap.
module obj_map_scan #(
  parameter int NOBJ = 32,
  localparam int AW  = $clog2(NOBJ)
) (
  input  logic [NOBJ-1:0] map_i,
  output logic [AW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NOBJ - 1; i >= 0; i--) begin
      if (map_i[i]) begin
        idx_o = AW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obj_fetch_unit.sv
// Per frame: walks the live-object bitmap, reads each object record and
// emits its outline as line segments over a valid/ready handshake.
module obj_fetch_unit
  import vpu_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int NOBJ   = 32,
  localparam int AW    = $clog2(NOBJ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NOBJ-1:0]      obj_map,
  input  logic                 mem_gnt,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [OBJ_REC_W-1:0] rd_data,
  output logic                 seg_vld,
  input  logic                 seg_rdy,
  output logic [COORD_W-1:0]   seg_x0,
  output logic [COORD_W-1:0]   seg_y0,
  output logic [COORD_W-1:0]   seg_x1,
  output logic [COORD_W-1:0]   seg_y1,
  output logic [COLOR_W-1:0]   seg_color,
  output logic [AW-1:0]        seg_obj,
  output logic                 seg_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [NOBJ-1:0] ONE = NOBJ'(1);

  fetch_state_t state_q, state_d;

  logic [NOBJ-1:0]     map_q, map_d, map_clr;
  logic [AW-1:0]       slot_q, slot_d;
  logic [AW-1:0]       scan_idx;
  logic                scan_any;
  logic                last_obj_q, last_obj_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [RSVD_LSB-1:0] rec_q, rec_d;
  logic [2:0]          edge_q, edge_d;

  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [AW-1:0]      obj_q, obj_d;

  obj_type_t          typ;
  logic [1:0]         vs, ve;
  logic               final_edge;
  logic [COORD_W-1:0] vx [MAX_VERTS];
  logic [COORD_W-1:0] vy [MAX_VERTS];
  logic               unused_rsvd;

  obj_map_scan #(
    .NOBJ (NOBJ)
  ) u_scan (
    .map_i (map_q),
    .idx_o (scan_idx),
    .any_o (scan_any)
  );

  assign unused_rsvd = ^rd_data[OBJ_REC_W-1:RSVD_LSB];
  assign map_clr     = map_q & ~(ONE << scan_idx);

  assign typ        = obj_type_t'(rec_q[TYPE_LSB +: TYPE_W]);
  assign final_edge = (edge_q == nsegs(typ) - 3'd1);
  assign vs         = edge_q[1:0];
  assign ve         = (edge_q + 3'd1 == nverts(typ)) ?
                      2'd0 : 2'(edge_q + 3'd1);

  always_comb begin
    for (int k = 0; k < MAX_VERTS; k++) begin
      vx[k] = rec_q[k*VERT_W +: COORD_W];
      vy[k] = rec_q[k*VERT_W+COORD_W +: COORD_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    slot_d     = slot_q;
    last_obj_d = last_obj_q;
    lat_d      = lat_q;
    rec_d      = rec_q;
    edge_d     = edge_q;
    vld_d      = vld_q;
    last_d     = last_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    obj_d      = obj_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          map_d   = obj_map;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_any) begin
          slot_d     = scan_idx;
          map_d      = map_clr;
          last_obj_d = (map_clr == '0);
          state_d    = REQ;
        end else begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      REQ: begin
        // The matrix unit owns memory whenever the grant is low.
        rd_en = mem_gnt;
        if (mem_gnt) begin
          lat_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LW'(RD_LAT - 1)) begin
          rec_d   = rd_data[RSVD_LSB-1:0];
          edge_d  = '0;
          state_d = EMIT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      EMIT: begin
        if (!vld_q) begin
          vld_d   = 1'b1;
          x0_d    = vx[vs];
          y0_d    = vy[vs];
          x1_d    = vx[ve];
          y1_d    = vy[ve];
          color_d = rec_q[COLOR_LSB +: COLOR_W];
          obj_d   = slot_q;
          last_d  = last_obj_q && final_edge;
        end else if (seg_rdy) begin
          vld_d = 1'b0;
          if (final_edge) begin
            state_d = SCAN;
          end else begin
            edge_d = edge_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      map_q      <= '0;
      slot_q     <= '0;
      last_obj_q <= 1'b0;
      lat_q      <= '0;
      rec_q      <= '0;
      edge_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      obj_q      <= '0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      slot_q     <= slot_d;
      last_obj_q <= last_obj_d;
      lat_q      <= lat_d;
      rec_q      <= rec_d;
      edge_q     <= edge_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      obj_q      <= obj_d;
    end
  end

  assign rd_addr   = slot_q;
  assign seg_vld   = vld_q;
  assign seg_x0    = x0_q;
  assign seg_y0    = y0_q;
  assign seg_x1    = x1_q;
  assign seg_y1    = y1_q;
  assign seg_color = color_q;
  assign seg_obj   = obj_q;
  assign seg_last  = last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_obj_fetch_unit.sv
// Randomized bench for obj_fetch_unit against a segment-list reference model.
module tb_obj_fetch_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  obj_map = '0;
  logic         mem_gnt = 1'b1;
  logic         rd_en;
  logic [4:0]   rd_addr;
  logic [143:0] rd_data = '0;
  logic         seg_vld;
  logic         seg_rdy = 1'b1;
  logic [15:0]  seg_x0, seg_y0, seg_x1, seg_y1;
  logic [7:0]   seg_color;
  logic [4:0]   seg_obj;
  logic         seg_last, busy, frame_done;

  typedef logic [77:0] seg_t;

  int     errors = 0;
  int     checks = 0;
  int     done_cnt = 0;
  int     rdy_pct = 100;
  int     gnt_pct = 100;
  int     stall_at = -1;
  int     stall_len = 0;
  int     poke_at = -1;
  bit     prev_stall = 1'b0;
  logic [78:0]  prev_view;
  logic [143:0] mem [32];
  seg_t   exp_q[$];
  seg_t   got_q[$];

  obj_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .obj_map    (obj_map),
    .mem_gnt    (mem_gnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .seg_vld    (seg_vld),
    .seg_rdy    (seg_rdy),
    .seg_x0     (seg_x0),
    .seg_y0     (seg_y0),
    .seg_x1     (seg_x1),
    .seg_y1     (seg_y1),
    .seg_color  (seg_color),
    .seg_obj    (seg_obj),
    .seg_last   (seg_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Video memory: one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic seg_t cur_seg();
    return {seg_x0, seg_y0, seg_x1, seg_y1, seg_color, seg_obj, seg_last};
  endfunction

  function automatic logic [143:0] mk(input int t, input int c,
                                      input int v[8]);
    logic [143:0] r;
    r = '0;
    r[143:138] = 6'h3F;
    r[137:130] = 8'(c);
    r[129:128] = 2'(t);
    for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(v[k]);
    return r;
  endfunction

  function automatic void build_exp(input logic [31:0] map);
    logic [143:0] r;
    int hi, t, nv, ns, a, b;
    hi = -1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) if (map[i]) hi = i;
    for (int i = 0; i < 32; i++) begin
      if (map[i]) begin
        r  = mem[i];
        t  = int'(r[129:128]);
        nv = t + 1;
        ns = (t == 1) ? 1 : nv;
        for (int e = 0; e < ns; e++) begin
          a = e;
          b = (e + 1) % nv;
          exp_q.push_back({r[32*a +: 16], r[32*a+16 +: 16],
                           r[32*b +: 16], r[32*b+16 +: 16],
                           r[137:130], 5'(i),
                           (i == hi && e == ns - 1)});
        end
      end
    end
  endfunction

  task automatic rand_mem();
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 9; k++) mem[i][16*k +: 16] = 16'($urandom);
  endtask

  task automatic load_three();
    mem[0] = mk(3, 8'h11, '{100, 100, 100, 200, 200, 200, 200, 100});
    mem[1] = mk(2, 8'h22, '{10, 20, 30, 40, 50, 60, 0, 0});
    mem[2] = mk(1, 8'h33, '{1, 2, 3, 4, 0, 0, 0, 0});
    mem[5] = mk(2, 8'h55, '{7, 7, 8, 8, 9, 9, 0, 0});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!mem_gnt) chk("rd_en_without_gnt", rd_en, 0);
      if (prev_stall) chk("seg_hold", {seg_vld, cur_seg()}, prev_view);
      if (seg_vld && seg_rdy) begin
        got_q.push_back(cur_seg());
        chk("seg_pending", 128'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("seg", cur_seg(), exp_q.pop_front());
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_all_segs", exp_q.size(), 0);
      end
      prev_stall = seg_vld && !seg_rdy;
      prev_view  = {seg_vld, cur_seg()};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    seg_rdy = ($urandom_range(99) < rdy_pct);
    mem_gnt = ($urandom_range(99) < gnt_pct);
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      start = 1'b0;
      n++;
      if (stall_len > 0 && got_q.size() == stall_at) begin
        seg_rdy = 1'b0;
        stall_len--;
      end
      if (poke_at >= 0 && got_q.size() == poke_at) begin
        obj_map[5] = ~obj_map[5];
        start      = 1'b1;
        poke_at    = -1;
      end
    end
    start = 1'b0;
    chk("frame_done_seen", 128'(done_cnt != d0), 1);
  endtask

  task automatic run_frame(input logic [31:0] map);
    int n_exp;
    obj_map = map;
    build_exp(map);
    n_exp = exp_q.size();
    got_q.delete();
    start = 1'b1;
    wait_done(20000);
    chk("seg_count", got_q.size(), n_exp);
  endtask

  task automatic check_three();
    chk("three_count", got_q.size(), 8);
    chk("first_seg", got_q[0][77:14], {16'd100, 16'd100, 16'd100, 16'd200});
    chk("quad_close", got_q[3][77:14], {16'd200, 16'd100, 16'd100, 16'd100});
    for (int i = 0; i < 8; i++) chk("last_flag", got_q[i][0], (i == 7));
  endtask

  initial begin
    int d0, n;
    rand_mem();
    load_three();
    @(negedge clk);
    chk("reset_outs", {rd_en, rd_addr, seg_vld, cur_seg(), busy, frame_done}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty map
    obj_map = '0;
    build_exp('0);
    start = 1'b1;
    @(negedge clk);
    chk("empty_done_early", frame_done, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("empty_done", frame_done, 1);
    chk("empty_no_seg", seg_vld, 0);
    @(negedge clk);
    chk("empty_done_pulse", frame_done, 0);
    chk("empty_idle", busy, 0);

    // Arbitration: grant withheld during the first request
    @(posedge clk);
    #1;
    gnt_pct = 0;
    mem_gnt = 1'b0;
    obj_map = 32'h7;
    build_exp(32'h7);
    got_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("arb_no_rd", rd_en, 0);
      chk("arb_addr", rd_addr, 0);
      chk("arb_busy", busy, 1);
      chk("arb_no_seg", seg_vld, 0);
      tick();
    end
    gnt_pct = 100;
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("arb_rd_go", {rd_en, rd_addr}, {1'b1, 5'd0});
    wait_done(2000);
    check_three();

    // Backpressure mid-tri, plus map change and start mid-frame
    stall_at  = 5;
    stall_len = 10;
    poke_at   = 6;
    run_frame(32'h7);
    check_three();
    repeat (10) tick();
    chk("restart_ignored", busy, 0);
    stall_at = -1;

    // Reset during the second quad segment
    obj_map = 32'h7;
    build_exp(32'h7);
    got_q.delete();
    start = 1'b1;
    n = 0;
    while (got_q.size() < 1 && n < 200) begin
      tick();
      start = 1'b0;
      n++;
    end
    seg_rdy = 1'b0;
    rdy_pct = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!seg_vld && n < 50);
    chk("rst_seg2_seen", seg_vld, 1);
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_seg_vld", seg_vld, 0);
    chk("rst_busy", busy, 0);
    rdy_pct = 100;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_done", done_cnt, d0);
    run_frame(32'h7);
    check_three();

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      rand_mem();
      rdy_pct = $urandom_range(100, 30);
      gnt_pct = $urandom_range(100, 30);
      if (f == 0) run_frame(32'hFFFF_FFFF);
      else if (f == 1) run_frame(32'h8000_0000);
      else run_frame($urandom & $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
